mem_port_ctl: RTL and testbench
===============================

# mem_port_ctl

Processor-side initiator for the multicycle MIPS unified memory. It accepts byte, halfword and word load/store requests from the datapath and drives the word-only memory port (write enable, word address, write data, combinational read data). Sub-word loads are implemented as lane extraction with sign or zero extension. Sub-word stores are implemented as a read-modify-write sequence. It sits between the multicycle control/datapath and the memory instance.

## Interface
- `MEM_WORDS`, 64, number of 32-bit words present; requests whose word index is `>= MEM_WORDS` are errors.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and returns an error.
- `req_signed`  in  1  load sign-extends when set; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  load result, extended; 0 for stores and errors.
- `resp_err`  out  1  misaligned address, illegal size, or out-of-range access.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  32  memory word address `{addr[31:2],2'b00}`.
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data, combinational from `mem_a`.

## Operation
- The design is big-endian. Byte lane `addr[1:0]=0` is `rd[31:24]` and lane 3 is `rd[7:0]`. A half at `addr[1]=0` is `rd[31:16]`.
- FSM states:
  - **IDLE**
    - `req_ready=1`.
    - On `req_valid`, latch `we/size/signed/addr/wdata`.
    - If the request is illegal, go to RESP with the error flag set. Otherwise go to ACCESS.
  - **ACCESS**
    - Drive `mem_a`.
    - Load: register the extracted and extended `mem_rd`, then go to RESP.
    - Store word: `mem_we=1`, `mem_wd=wdata`, then go to RESP.
    - Sub-word store: register `mem_rd` into a merge buffer, then go to WRITE.
  - **WRITE**
    - Drive `mem_a`.
    - `mem_we=1`, `mem_wd` = buffered word with the target lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
    - Go to RESP.
  - **RESP**
    - `resp_valid=1`; outputs stay stable until `resp_ready`.
    - On `resp_valid && resp_ready`, go to IDLE.
- Illegal requests:
  - Size 3.
  - Half with `addr[0]=1`.
  - Word with `addr[1:0]!=0`.
  - `addr[31:2] >= MEM_WORDS`.
  - An illegal request never asserts `mem_we` and never enters ACCESS.
- Only one request is outstanding at a time. `req_ready=0` in all states except IDLE.
- Outside ACCESS and WRITE: `mem_we=0`, `mem_a=0`, `mem_wd=0`.

## Timing
- Reset values (while `reset` is high and the cycle after):
  - State is IDLE.
  - `req_ready=0` while `reset` is high, then 1.
  - `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0`.
- Timing is counted from the accept edge (cycle 0):
  - Load and store word: `resp_valid` is asserted in cycle 2.
  - Sub-word store: `resp_valid` is asserted in cycle 3.
  - Error: `resp_valid` is asserted in cycle 1.
- `mem_we` is high for exactly one cycle per legal store. The write commits on the rising edge that ends ACCESS (word store) or WRITE (sub-word store).
- The minimum request-to-request spacing is 3 cycles for loads and store words.
- Reset mid-operation aborts the request with no response. A write not yet committed at the reset edge never occurs. Reset in RESP drops the response.
- Stalling with `resp_ready` low has no memory side effects.

## Structure
- Shared package `mem_port_pkg` holds:
  - size encodings `SZ_BYTE/SZ_HALF/SZ_WORD`;
  - the state enum (IDLE, ACCESS, WRITE, RESP);
  - the endian lane-index function.
- Sub-module `mem_lane_align` is purely combinational and contains:
  - load extraction and extension (addr, size, signed, rd → rdata);
  - store merge (addr, size, old word, wdata → new word).
- The FSM, request latch and merge buffer live in `mem_port_ctl`.

## Test plan
- **Byte loads:** preload word 0x10 = `0x8899AABB`.
  - `lb` at 0x11 with signed → `resp_rdata=0xFFFFFF99`, `resp_valid` in cycle 2, `mem_we` never high.
  - `lbu` at the same address → `0x00000099`.
- **Halfword store:** `sh` at 0x12, `wdata=0x0000_1234`, over `0x8899AABB`.
  - Word becomes `0x88991234`.
  - `mem_we` is high only in cycle 2 with `mem_a=0x10`.
  - `resp_valid` in cycle 3, `resp_err=0`.
- **Misaligned and illegal size:** `sw` at 0x06 → `resp_err=1`, `resp_valid` in cycle 1, no `mem_we`; size 3 at 0x00 behaves the same.
- **Out of range:** `lw` at 0x100 with `MEM_WORDS=64` → `resp_err=1`, `resp_rdata=0`, no memory access.
- **Backpressure:** hold `resp_ready` low 3 cycles after `lw` at 0x10.
  - `resp_rdata=0x8899AABB` stays stable and `req_ready=0` throughout.
  - Accept on the 4th cycle; `req_ready=1` the next cycle.
- **Reset abort:** assert `reset` in ACCESS of `sb` at 0x13.
  - `mem_we` never asserts and the memory word is unchanged.
  - No `resp_valid`.
  - All outputs are at reset values the next cycle.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared definitions for the processor-side memory port controller.
package mem_port_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Big-endian lane position: right shift that brings the addressed
    // byte/half down to bit 0 of a memory word (byte lane 0 is bits 31:24).
    function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo,
                                              input logic [1:0] size);
        logic [4:0] sh;
        sh = 5'd0;
        case (size)
            SZ_BYTE: sh = {~addr_lo, 3'b000};
            SZ_HALF: sh = {~addr_lo[1], 4'b0000};
            default: sh = 5'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extraction/extension and store merge.
module mem_lane_align
    import mem_port_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] rd,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] new_word
);

    logic [4:0]  sh;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] lane_mask;

    // Extract the addressed lane from the read word and extend it
    always_comb begin
        sh      = lane_shift(addr_lo, size);
        shifted = rd >> sh;
        case (size)
            SZ_BYTE: rdata = sgn ? {{24{shifted[7]}}, shifted[7:0]}
                                 : {24'h000000, shifted[7:0]};
            SZ_HALF: rdata = sgn ? {{16{shifted[15]}}, shifted[15:0]}
                                 : {16'h0000, shifted[15:0]};
            default: rdata = rd;
        endcase
    end

    // Replace the target lane(s) of the old word with right-justified wdata
    always_comb begin
        case (size)
            SZ_BYTE: mask = 32'h0000_00FF;
            SZ_HALF: mask = 32'h0000_FFFF;
            default: mask = '1;
        endcase
        lane_mask = mask << sh;
        new_word  = (old_word & ~lane_mask) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/mem_port_ctl.sv
// Processor-side initiator for the word-only unified memory port.
module mem_port_ctl
    import mem_port_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_t      state, state_n;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_illegal;
    logic [31:0] ld_data;
    logic [31:0] merged;
    logic [31:0] word_a;
    logic        mem_we_c;
    logic [31:0] mem_a_c;
    logic [31:0] mem_wd_c;

    mem_lane_align u_align (
        .addr_lo  (addr_q[1:0]),
        .size     (size_q),
        .sgn      (sgn_q),
        .rd       (mem_rd),
        .old_word (buf_q),
        .wdata    (wdata_q),
        .rdata    (ld_data),
        .new_word (merged)
    );

    assign word_a = {addr_q[31:2], 2'b00};

    // Classify the incoming request before it is accepted
    always_comb begin
        req_illegal = 1'b0;
        if (req_size == 2'd3)
            req_illegal = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])
            req_illegal = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_illegal = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_illegal = 1'b1;
    end

    // State register, request latch, merge buffer and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        sgn_q   <= req_signed;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_illegal;
                        rdata_q <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q)
                        rdata_q <= ld_data;
                    else if (size_q != SZ_WORD)
                        buf_q <= mem_rd;
                end
                default: ;
            endcase
        end
    end

    // Next-state and memory-port drive
    always_comb begin
        state_n  = state;
        mem_we_c = 1'b0;
        mem_a_c  = '0;
        mem_wd_c = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid)
                    state_n = req_illegal ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_a_c = word_a;
                if (we_q && size_q == SZ_WORD) begin
                    mem_we_c = 1'b1;
                    mem_wd_c = wdata_q;
                    state_n  = ST_RESP;
                end else if (we_q) begin
                    state_n = ST_WRITE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            ST_WRITE: begin
                mem_a_c  = word_a;
                mem_we_c = 1'b1;
                mem_wd_c = merged;
                state_n  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are forced to reset values while reset is high so that a write
    // pending in ACCESS/WRITE cannot commit on the reset edge.
    always_comb begin
        req_ready  = !reset && (state == ST_IDLE);
        resp_valid = !reset && (state == ST_RESP);
        resp_rdata = resp_valid ? rdata_q : '0;
        resp_err   = resp_valid && err_q;
        mem_we     = !reset && mem_we_c;
        mem_a      = reset ? '0 : mem_a_c;
        mem_wd     = reset ? '0 : mem_wd_c;
    end

endmodule

// File: tb/tb_mem_port_ctl.sv
// Self-checking bench for mem_port_ctl against a byte-array memory model.
module tb_mem_port_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Backing memory driven by the DUT, with a bench-side preload path
    logic [31:0] mem [64];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_val;

    // Reference model: the same memory seen as 256 big-endian bytes
    logic [7:0]  mb [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_port_ctl #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_we)
            mem[mem_a[7:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input int idx);
        return {mb[idx*4], mb[idx*4+1], mb[idx*4+2], mb[idx*4+3]};
    endfunction

    function automatic logic model_illegal(input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (size == 2'd3) return 1'b1;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return 1'b1;
        if ((addr / 4) >= 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [31:0] addr);
        int a;
        logic [31:0] v;
        a = int'(addr[7:0]);
        v = 32'h0;
        case (size)
            2'd0: begin
                v = {24'h0, mb[a]};
                if (sgn && mb[a][7]) v = v | 32'hFFFF_FF00;
            end
            2'd1: begin
                v = {16'h0, mb[a], mb[a+1]};
                if (sgn && mb[a][7]) v = v | 32'hFFFF_0000;
            end
            default: v = {mb[a], mb[a+1], mb[a+2], mb[a+3]};
        endcase
        return v;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd);
        int a;
        int n;
        a = int'(addr[7:0]);
        n = 1 << size;
        for (int i = 0; i < n; i++)
            mb[a+i] = wd[8*(n-1-i) +: 8];
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        for (int i = 0; i < 4; i++)
            mb[idx*4+i] = val[8*(3-i) +: 8];
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // One complete transaction with timing, data and memory-side checks.
    // hold = number of response cycles with resp_ready low before accepting.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int hold, output logic [31:0] got);
        logic        exp_err;
        int          exp_lat;
        logic [31:0] exp_rdata;
        int          lat;
        int          we_cnt;
        int          we_cyc;
        logic [31:0] we_addr;
        int          idx;

        exp_err   = model_illegal(size, addr);
        exp_lat   = exp_err ? 1 : ((we && size != 2'd2) ? 3 : 2);
        exp_rdata = (!exp_err && !we) ? model_load(size, sgn, addr) : 32'h0;
        if (!exp_err && we) model_store(size, addr, wd);

        @(negedge clk);
        resp_ready = (hold == 0);
        check("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;

        lat = -1; we_cnt = 0; we_cyc = -1; we_addr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_we) begin
                we_cnt++;
                we_cyc  = k;
                we_addr = mem_a;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat < 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL resp_timeout observed=none expected=cycle %0d", exp_lat);
        end
        check("resp_latency", 32'(lat), 32'(exp_lat));
        check("resp_err", {31'h0, resp_err}, {31'h0, exp_err});
        check("resp_rdata", resp_rdata, exp_rdata);
        check("ready_in_resp", {31'h0, req_ready}, 32'h0);
        got = resp_rdata;

        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (mem_we) we_cnt++;
                check("stall_valid", {31'h0, resp_valid}, 32'h1);
                check("stall_rdata", resp_rdata, exp_rdata);
                check("stall_ready", {31'h0, req_ready}, 32'h0);
            end
            @(posedge clk);
            #1;
            if (mem_we) we_cnt++;
            resp_ready = 1'b1;
            check("stall_last_valid", {31'h0, resp_valid}, 32'h1);
            check("stall_last_rdata", resp_rdata, exp_rdata);
        end

        check("mem_we_count", 32'(we_cnt), (!exp_err && we) ? 32'h1 : 32'h0);
        if (!exp_err && we) begin
            check("mem_we_cycle", 32'(we_cyc), 32'(exp_lat - 1));
            check("mem_we_addr", we_addr, {addr[31:2], 2'b00});
        end

        @(posedge clk);
        #1;
        check("ready_after_resp", {31'h0, req_ready}, 32'h1);
        check("valid_after_resp", {31'h0, resp_valid}, 32'h0);
        idx = int'(addr[7:2]);
        check("mem_contents", mem[idx], model_word(idx));
    endtask

    initial begin
        logic [31:0] got;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
        pl_en = 1'b0; pl_idx = '0; pl_val = '0;

        for (int i = 0; i < 64; i++)
            preload(i, (i == 4) ? 32'h8899_AABB : $urandom);

        // Reset values while reset is held
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", {31'h0, req_ready}, 32'h1);

        // Byte loads from 0x8899AABB
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, got);
        check("lb_value", got, 32'hFFFF_FF99);
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0, got);
        check("lbu_value", got, 32'h0000_0099);

        // Backpressure on a word load
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, got);
        check("lw_bp_value", got, 32'h8899_AABB);

        // Halfword store merge
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 0, got);
        check("sh_word", mem[4], 32'h8899_1234);

        // Misaligned, illegal size, out of range
        do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'hDEAD_BEEF, 0, got);
        do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 0, got);
        do_req(1'b1, 2'd3, 1'b0, 32'h00, 32'hCAFE_F00D, 0, got);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, got);

        // Reset during ACCESS of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h13; req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_mem_we", {31'h0, mem_we}, 32'h0);
        check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("abort_req_ready", {31'h0, req_ready}, 32'h0);
        check("abort_rdata", resp_rdata, 32'h0);
        check("abort_err", {31'h0, resp_err}, 32'h0);
        check("abort_mem_we2", {31'h0, mem_we}, 32'h0);
        check("abort_mem_a", mem_a, 32'h0);
        check("abort_mem_wd", mem_wd, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        check("abort_word", mem[4], model_word(4));

        // Randomized traffic against the byte model
        for (int t = 0; t < 80; t++) begin
            r  = $urandom_range(0, 6);
            sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 9) == 0)
                ad = 32'($urandom_range(256, 1023));
            else
                ad = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                ad = ad & ~((32'h1 << sz) - 32'h1);
            do_req(1'($urandom), sz, 1'($urandom), ad, $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
